// File: rtl/mem_responder.sv
// Single-port word memory behind a valid/ready request and response handshake.
// Each accepted request waits WAIT_CYCLES wait states, then performs its access
// and holds the response until the initiator takes it.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | ready for a new request (req_ready=1 when not in reset)
// ST_WAIT | request latched, counting down wait states
// ST_RESP | access done, response held until resp_ready
module mem_responder #(
  parameter int SIZE        = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int CW = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);
  localparam int AW = (SIZE < 2) ? 1 : $clog2(SIZE);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t          state, next_state;
  logic [CW-1:0]   cnt, next_cnt;
  logic            accept;
  logic            access;
  logic            write_q;
  logic [31:0]     addr_q;
  logic [31:0]     wdata_q;
  logic [3:0]      wstrb_q;
  logic            addr_err;
  logic [AW-1:0]   word_idx;
  logic [31:0]     mem [SIZE];

  // Misaligned or beyond-depth addresses are errors; upper bits take part in
  // the range compare so large addresses never alias onto low words.
  assign addr_err = (addr_q[1:0] != 2'b00) || ({2'b00, addr_q[31:2]} >= 32'(SIZE));
  assign word_idx = addr_q[AW+1:2];

  // State and wait counter register; reset drops back to idle at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
    end
  end

  // Next-state, counter and handshake outputs.
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    accept     = 1'b0;
    access     = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready = reset;
        if (req_valid && reset) begin
          accept     = 1'b1;
          next_state = ST_WAIT;
          next_cnt   = CNT_LOAD;
        end
      end
      ST_WAIT: begin
        if (cnt == '0) begin
          access     = 1'b1;
          next_state = ST_RESP;
        end else begin
          next_cnt = cnt - CW'(1);
        end
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Request capture on acceptance and response capture at the access edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      write_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      if (accept) begin
        write_q <= req_write;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        wstrb_q <= req_wstrb;
      end
      if (access) begin
        resp_err   <= addr_err;
        resp_rdata <= (addr_err || write_q) ? 32'h0 : mem[word_idx];
      end
    end
  end

  // Storage is deliberately outside the reset domain so contents survive reset.
  always_ff @(posedge clk) begin
    if (access && write_q && !addr_err) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb_q[i]) mem[word_idx][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Randomized bench for mem_responder with a word-array reference model.
module tb_mem_responder;

  localparam int SIZE = 64;
  localparam int W    = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_wstrb = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] model [SIZE];

  mem_responder #(.SIZE(SIZE), .WAIT_CYCLES(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_wstrb  (req_wstrb),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Drive request fields that must be ignored while the responder is busy.
  task automatic drive_garbage();
    req_valid = 1'($urandom_range(0, 1));
    req_write = 1'($urandom_range(0, 1));
    req_addr  = 32'($urandom_range(0, SIZE - 1)) << 2;
    req_wdata = $urandom;
    req_wstrb = 4'hF;
  endtask

  task automatic xact(input bit w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input int bp,
                      output logic [31:0] rd, output logic er);
    int lat;
    @(negedge clk);
    req_valid  = 1'b1;
    req_write  = w;
    req_addr   = a;
    req_wdata  = d;
    req_wstrb  = s;
    resp_ready = 1'b0;
    check("req_ready_idle", {31'b0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    drive_garbage();
    lat = 1;
    while (!resp_valid && lat < W + 10) begin
      @(posedge clk);
      #1;
      lat++;
      drive_garbage();
    end
    check("latency", 32'(lat), 32'(W + 2));
    rd = resp_rdata;
    er = resp_err;
    check("req_ready_busy", {31'b0, req_ready}, 32'd0);
    for (int i = 0; i < bp; i++) begin
      @(posedge clk);
      #1;
      check("bp_valid", {31'b0, resp_valid}, 32'd1);
      check("bp_rdata", resp_rdata, rd);
      check("bp_err", {31'b0, resp_err}, {31'b0, er});
      check("bp_req_ready", {31'b0, req_ready}, 32'd0);
      drive_garbage();
    end
    @(negedge clk);
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("resp_drop", {31'b0, resp_valid}, 32'd0);
    resp_ready = 1'b0;
  endtask

  task automatic op(input bit w, input logic [31:0] a, input logic [31:0] d,
                    input logic [3:0] s, input int bp, output logic [31:0] rd);
    logic        er;
    logic        exp_er;
    logic [31:0] exp_rd;
    int          idx;
    xact(w, a, d, s, bp, rd, er);
    exp_er = (a[1:0] != 2'b00) || (a / 4 >= SIZE);
    idx    = int'(a / 4);
    exp_rd = (!exp_er && !w) ? model[idx] : 32'h0;
    check("resp_err", {31'b0, er}, {31'b0, exp_er});
    check("resp_rdata", rd, exp_rd);
    if (w && !exp_er) begin
      for (int i = 0; i < 4; i++)
        if (s[i]) model[idx][8*i +: 8] = d[8*i +: 8];
    end
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] a;
    int          r;

    #2;
    check("rst_req_ready", {31'b0, req_ready}, 32'd0);
    check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_resp_err", {31'b0, resp_err}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_reset", {31'b0, req_ready}, 32'd1);

    for (int i = 0; i < SIZE; i++) op(1'b1, 32'(i) << 2, $urandom, 4'hF, 0, rd);

    op(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, rd);
    op(1'b0, 32'h10, 32'h0, 4'h0, 0, rd);
    check("load_deadbeef", rd, 32'hDEADBEEF);

    op(1'b1, 32'h20, 32'h11223344, 4'hF, 0, rd);
    op(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 0, rd);
    op(1'b0, 32'h20, 32'h0, 4'h0, 0, rd);
    check("lane_merge", rd, 32'h11BB33DD);

    op(1'b0, 32'(4 * SIZE), 32'h0, 4'h0, 0, rd);
    op(1'b1, 32'(4 * SIZE), 32'hFFFFFFFF, 4'hF, 0, rd);
    op(1'b0, 32'h0, 32'h0, 4'h0, 0, rd);

    op(1'b1, 32'h22, 32'h5A5A5A5A, 4'hF, 0, rd);
    op(1'b0, 32'h20, 32'h0, 4'h0, 0, rd);
    check("misalign_keep_20", rd, 32'h11BB33DD);
    op(1'b0, 32'h24, 32'h0, 4'h0, 0, rd);

    op(1'b1, 32'h10, 32'h01020304, 4'h0, 0, rd);
    op(1'b0, 32'h10, 32'h0, 4'h0, 5, rd);
    check("wstrb0_noop", rd, 32'hDEADBEEF);

    op(1'b1, 32'h40, 32'hCAFEF00D, 4'hF, 0, rd);
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 32'h40;
    req_wdata = 32'h12345678;
    req_wstrb = 4'hF;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("abort_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("abort_req_ready", {31'b0, req_ready}, 32'd0);
    check("abort_resp_rdata", resp_rdata, 32'h0);
    check("abort_resp_err", {31'b0, resp_err}, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_abort", {31'b0, req_ready}, 32'd1);
    op(1'b0, 32'h40, 32'h0, 4'h0, 0, rd);
    check("abort_no_write", rd, 32'hCAFEF00D);

    for (int n = 0; n < 300; n++) begin
      r = int'($urandom_range(0, 9));
      if (r < 7)       a = 32'($urandom_range(0, SIZE - 1)) << 2;
      else if (r == 7) a = (32'($urandom_range(0, SIZE - 1)) << 2) | 32'($urandom_range(1, 3));
      else if (r == 8) a = 32'(4 * SIZE) + (32'($urandom_range(0, 63)) << 2);
      else             a = $urandom;
      op(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
         int'($urandom_range(0, 3)), rd);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
